// File: rtl/iir_biquad_mc_if.sv
// Handshake bundle for iir_biquad_mc: coefficient load, sample input, filtered output.
// master = upstream/downstream environment, slave = the filter.
interface iir_biquad_mc_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 16,
  parameter int CH_W   = 1
);
  logic              start;
  logic              coef_valid;
  logic [COEF_W-1:0] coef_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] din;
  logic [CH_W-1:0]   in_ch;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] dout;
  logic [CH_W-1:0]   out_ch;
  logic              done;

  modport master (
    output start, coef_valid, coef_data, in_valid, din, in_ch, out_ready,
    input  in_ready, out_valid, dout, out_ch, done
  );

  modport slave (
    input  start, coef_valid, coef_data, in_valid, din, in_ch, out_ready,
    output in_ready, out_valid, dout, out_ch, done
  );
endinterface

// File: rtl/iir_biquad_mc.sv
// Multi-channel time-multiplexed biquad IIR filter, one multiply per cycle.
// y = b0*x + b1*x1 + b2*x2 + a1*y1 + a2*y2, result >>> FRAC_BITS.
// Optional macro IIR_BIQUAD_SAT_EN: saturate the scaled result instead of wrapping.
module iir_biquad_mc #(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int NUM_CH    = 1,
  parameter int FRAME_LEN = 100
) (
  input logic            clk,
  input logic            reset,
  iir_biquad_mc_if.slave bus
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SLOTS  = 1 << CH_W;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + 3;
  localparam int CNT_W  = $clog2(FRAME_LEN + 1);
  localparam logic [CH_W:0]    NUM_CH_L    = (CH_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] FRAME_LEN_L = CNT_W'(FRAME_LEN);

  typedef enum logic [3:0] {
    StIdle, StLoad, StWaitIn, StMac0, StMac1, StMac2, StMac3, StMac4, StScale, StOut
  } state_e;

  state_e state_q, state_d;

  logic signed [COEF_W-1:0] a1_q, a2_q, b0_q, b1_q, b2_q;
  logic signed [DATA_W-1:0] x1_q [SLOTS];
  logic signed [DATA_W-1:0] x2_q [SLOTS];
  logic signed [DATA_W-1:0] y1_q [SLOTS];
  logic signed [DATA_W-1:0] y2_q [SLOTS];
  logic signed [DATA_W-1:0] x_q;
  logic [CH_W-1:0]          ch_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] dout_q;
  logic                     done_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [2:0]               idx_q;

  logic                     ch_ok;
  logic                     last_xfer;
  logic signed [COEF_W-1:0] mac_coef;
  logic signed [DATA_W-1:0] mac_data;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_add;
  logic signed [DATA_W-1:0] scaled;

  // Out-of-range channels are swallowed in WAIT_IN without starting a MAC pass
  assign ch_ok     = ({1'b0, bus.in_ch} < NUM_CH_L);
  assign last_xfer = (cnt_q == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (bus.start) state_d = StLoad;
      StLoad:   if (bus.coef_valid && idx_q == 3'd4) state_d = StWaitIn;
      StWaitIn: if (bus.in_valid && ch_ok) state_d = StMac0;
      StMac0:   state_d = StMac1;
      StMac1:   state_d = StMac2;
      StMac2:   state_d = StMac3;
      StMac3:   state_d = StMac4;
      StMac4:   state_d = StScale;
      StScale:  state_d = StOut;
      StOut:    if (bus.out_ready) state_d = last_xfer ? StIdle : StWaitIn;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and registered datapath values
  always_comb begin
    bus.in_ready  = (state_q == StWaitIn);
    bus.out_valid = (state_q == StOut);
    bus.dout      = dout_q;
    bus.out_ch    = ch_q;
    bus.done      = done_q;
  end

  // Select the coefficient/history pair multiplied in each MAC state
  always_comb begin
    mac_coef = '0;
    mac_data = '0;
    case (state_q)
      StMac0: begin mac_coef = b0_q; mac_data = x_q;        end
      StMac1: begin mac_coef = b1_q; mac_data = x1_q[ch_q]; end
      StMac2: begin mac_coef = b2_q; mac_data = x2_q[ch_q]; end
      StMac3: begin mac_coef = a1_q; mac_data = y1_q[ch_q]; end
      StMac4: begin mac_coef = a2_q; mac_data = y2_q[ch_q]; end
      default: ;
    endcase
  end

  assign prod    = PROD_W'(mac_coef) * PROD_W'(mac_data);
  assign acc_add = ACC_W'(prod);

`ifdef IIR_BIQUAD_SAT_EN
  // Result sign bit plus every accumulator bit above it; all equal means it fits
  logic [ACC_W-FRAC_BITS-DATA_W:0] top_bits;

  // Floor shift, then clamp to the DATA_W signed range
  always_comb begin
    top_bits = acc_q[ACC_W-1:FRAC_BITS+DATA_W-1];
    if (&top_bits || ~|top_bits) scaled = acc_q[FRAC_BITS +: DATA_W];
    else if (acc_q[ACC_W-1])     scaled = {1'b1, {(DATA_W-1){1'b0}}};
    else                         scaled = {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  // Floor shift and keep the low DATA_W bits (two's-complement wrap)
  assign scaled = acc_q[FRAC_BITS +: DATA_W];
`endif

  // Datapath: coefficient capture, sample latch, accumulation, history update
  always_ff @(posedge clk) begin
    if (reset) begin
      a1_q   <= '0;
      a2_q   <= '0;
      b0_q   <= '0;
      b1_q   <= '0;
      b2_q   <= '0;
      x_q    <= '0;
      ch_q   <= '0;
      acc_q  <= '0;
      dout_q <= '0;
      done_q <= 1'b0;
      cnt_q  <= FRAME_LEN_L;
      idx_q  <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            cnt_q <= FRAME_LEN_L;
            idx_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
              x1_q[i] <= '0;
              x2_q[i] <= '0;
              y1_q[i] <= '0;
              y2_q[i] <= '0;
            end
          end
        end
        StLoad: begin
          if (bus.coef_valid) begin
            case (idx_q)
              3'd0:    a1_q <= bus.coef_data;
              3'd1:    a2_q <= bus.coef_data;
              3'd2:    b0_q <= bus.coef_data;
              3'd3:    b1_q <= bus.coef_data;
              default: b2_q <= bus.coef_data;
            endcase
            idx_q <= idx_q + 3'd1;
          end
        end
        StWaitIn: begin
          if (bus.in_valid && ch_ok) begin
            x_q  <= bus.din;
            ch_q <= bus.in_ch;
          end
        end
        StMac0:  acc_q  <= acc_add;
        StMac1,
        StMac2,
        StMac3,
        StMac4:  acc_q  <= acc_q + acc_add;
        StScale: dout_q <= scaled;
        StOut: begin
          if (bus.out_ready) begin
            x2_q[ch_q] <= x1_q[ch_q];
            x1_q[ch_q] <= x_q;
            y2_q[ch_q] <= y1_q[ch_q];
            y1_q[ch_q] <= dout_q;
            cnt_q      <= cnt_q - CNT_W'(1);
            if (last_xfer) done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/iir_biquad_mc.md
IIR_BIQUAD_MC -- requirements
Module: iir_biquad_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 8, sample width (signed two's complement).
REQ-002 SHALL have parameter COEF_W, default 16, coefficient width (signed).
REQ-003 SHALL have parameter FRAC_BITS, default 8, number of fractional bits in each coefficient.
REQ-004 SHALL have parameter NUM_CH, default 1, count of independent time-multiplexed channels (1..16).
REQ-005 SHALL have parameter FRAME_LEN, default 100, samples processed per coefficient load.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 reset  in  1  reset; synchronous and active-high.
REQ-008 start  in  1  one-cycle request that begins a coefficient load.
REQ-009 coef_valid  in  1  coef_data is valid this cycle.
REQ-010 coef_data  in  COEF_W  coefficient word, sent in order a1, a2, b0, b1, b2.
REQ-011 in_valid  in  1  sample offered.
REQ-012 in_ready  out  1  block accepts a sample this cycle.
REQ-013 din  in  DATA_W  input sample.
REQ-014 in_ch  in  clog2(NUM_CH) min 1  channel of din.
REQ-015 out_valid  out  1  dout valid; held until out_ready.
REQ-016 out_ready  in  1  downstream accepts dout.
REQ-017 dout  out  DATA_W  filtered sample.
REQ-018 out_ch  out  clog2(NUM_CH) min 1  channel of dout.
REQ-019 done  out  1  one-cycle pulse after the FRAME_LEN-th output transfer.

Function
REQ-020 SHALL compute y = b0*x + b1*x1 + b2*x2 + a1*y1 + a2*y2 per channel, where x1/x2/y1/y2 are that channel's previous inputs/outputs.
REQ-021 SHALL implement states IDLE, LOAD, WAIT_IN, MAC0..MAC4, SCALE, OUT.
REQ-022 IDLE -> LOAD on start; LOAD captures one coefficient per coef_valid cycle, -> WAIT_IN after the fifth.
REQ-023 On entering LOAD, all channel histories SHALL clear to 0 and the frame counter SHALL load FRAME_LEN.
REQ-024 in_ready SHALL be 1 only in WAIT_IN; sample accepted on in_valid & in_ready at cycle T.
REQ-025 One product SHALL accumulate per MAC state into a signed accumulator of DATA_W+COEF_W+3 bits with no overflow.
REQ-026 SCALE SHALL arithmetic-shift the accumulator right by FRAC_BITS (floor rounding).
REQ-027 out_valid SHALL assert at T+7 in state OUT, holding dout/out_ch stable until out_ready.
REQ-028 On output transfer: channel x2<=x1, x1<=x, y2<=y1, y1<=dout; then frame counter decrements.
REQ-029 If the counter reaches 0 on transfer, done SHALL pulse next cycle and state -> IDLE; else -> WAIT_IN.
REQ-030 Sample with in_ch >= NUM_CH SHALL be accepted and discarded: no output, no history or counter change, stays in WAIT_IN.
REQ-031 start outside IDLE and coef_valid outside LOAD SHALL be ignored.
REQ-032 Histories and coefficients SHALL persist across frames until the next LOAD.

Reset
REQ-033 reset SHALL take priority over all inputs in the same cycle, including mid-LOAD or mid-MAC.
REQ-034 On reset: state IDLE, in_ready 0, out_valid 0, dout 0, out_ch 0, done 0, coefficients 0, histories 0, frame counter FRAME_LEN.

Configuration
REQ-035 With macro IIR_BIQUAD_SAT_EN defined, SCALE SHALL saturate the result to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-036 Without IIR_BIQUAD_SAT_EN, SCALE SHALL truncate to the low DATA_W bits (two's-complement wrap).

Verification (defaults unless stated; 1.0 = 0x0100)
REQ-037 Pass-through: coefs a1=a2=0, b0=0x0100, b1=b2=0; din 0x25 ch0 -> dout 0x25 at T+7.
REQ-038 Recursion: a1=0x0080, b0=0x0100; din 64,0,0 -> dout 64,32,16.
REQ-039 Saturation: b0=0x0200; din 100 -> dout 127 with IIR_BIQUAD_SAT_EN, 0xC8 (-56) without.
REQ-040 Channels, NUM_CH=2: a1=0x0080, b0=0x0100; ch0 din 64, ch1 din 0, ch0 din 0 -> outputs ch0 64, ch1 0, ch0 32.
REQ-041 Backpressure: out_ready low 3 cycles in OUT -> out_valid, dout stable and in_ready 0 throughout; one transfer on release.
REQ-042 Frame/reset: FRAME_LEN=3 -> done pulses once after third transfer, state IDLE; reset asserted during MAC2 -> all outputs at reset values next cycle.
